// File: rtl/shift_deserializer_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
package shift_pkg;

  // Receiver framing states: waiting for a frame marker, or collecting bits.
  typedef enum logic {S_IDLE, S_SHIFT} deser_state_t;

  // Bit counter width; a one-bit word would still need a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/deser_out_buf.sv
// One-entry output holding register with a valid/ready handshake.
// A completed word is dropped (and overrun latched) only when the
// previous word is still waiting and downstream is not taking it.
module deser_out_buf
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             overrun
);

  // Load on empty or on a same-cycle drain, otherwise flag the lost word.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      overrun   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      overrun   <= 1'b0;
    end else if (load) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        data_out  <= word;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver: gathers framed serial bits into
// WIDTH-bit words and hands them off through a one-entry buffer.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     ser_valid,
  input  logic                     ser_data,
  input  logic                     frame_start,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  deser_state_t     state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] next_sreg;
  logic             accept;
  logic             word_done;

  // Next shift value and whether this bit is taken / finishes a word.
  // A frame_start bit is always bit 0, so it can never complete a word.
  always_comb begin
    next_sreg = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], ser_data}
                                 : {ser_data, sreg[WIDTH-1:1]};
    accept    = ser_valid && (frame_start || (state == S_SHIFT));
    word_done = accept && !frame_start && (bit_cnt == LAST_BIT);
  end

  // Framing FSM, bit counter and shift register; frame_err is a one-cycle pulse.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      sreg      <= '0;
      frame_err <= 1'b0;
    end else if (clear) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      sreg      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (accept) begin
        sreg <= next_sreg;
        if (frame_start) begin
          frame_err <= (state == S_SHIFT) && (bit_cnt != '0);
          bit_cnt   <= CNT_W'(1);
          state     <= S_SHIFT;
        end else if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  deser_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clock    (clock),
    .rst      (rst),
    .clear    (clear),
    .load     (word_done),
    .word     (next_sreg),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .data_out (data_out),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: one MSB-first and one
// LSB-first instance share the same stimulus.
module tb_shift_deserializer;

  logic       clock = 1'b0;
  logic       rst;
  logic       clear;
  logic       ser_valid;
  logic       ser_data;
  logic       frame_start;
  logic       out_ready;

  logic       valid_m, valid_l;
  logic [3:0] data_m, data_l;
  logic [1:0] cnt_m, cnt_l;
  logic       ferr_m, ferr_l;
  logic       ovr_m, ovr_l;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  shift_deserializer #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clock(clock), .rst(rst), .clear(clear), .ser_valid(ser_valid),
    .ser_data(ser_data), .frame_start(frame_start), .out_valid(valid_m),
    .out_ready(out_ready), .data_out(data_m), .bit_cnt(cnt_m),
    .frame_err(ferr_m), .overrun(ovr_m)
  );

  shift_deserializer #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clock(clock), .rst(rst), .clear(clear), .ser_valid(ser_valid),
    .ser_data(ser_data), .frame_start(frame_start), .out_valid(valid_l),
    .out_ready(out_ready), .data_out(data_l), .bit_cnt(cnt_l),
    .frame_err(ferr_l), .overrun(ovr_l)
  );

  // Reference model: the partial word is a plain list of received bits.
  bit         m_bits[$];
  bit         m_inframe;
  logic       m_v;
  logic [3:0] m_wm, m_wl;
  logic       m_fe, m_ov;

  task automatic modelReset();
    m_bits.delete();
    m_inframe = 1'b0;
    m_v  = 1'b0;
    m_wm = 4'h0;
    m_wl = 4'h0;
    m_fe = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic modelStep(input logic clr, input logic sv, input logic sd,
                           input logic fs, input logic rdy);
    bit         done;
    logic [3:0] wm, wl;
    done = 1'b0;
    wm   = 4'h0;
    wl   = 4'h0;
    if (clr) begin
      modelReset();
    end else begin
      m_fe = 1'b0;
      if (sv) begin
        if (fs) begin
          m_fe = (m_bits.size() != 0);
          m_bits.delete();
          m_bits.push_back(sd);
          m_inframe = 1'b1;
        end else if (m_inframe) begin
          m_bits.push_back(sd);
          if (m_bits.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
              wm[3-i] = m_bits[i];
              wl[i]   = m_bits[i];
            end
            done = 1'b1;
            m_bits.delete();
          end
        end
      end
      if (done) begin
        if (!m_v || rdy) begin
          m_v  = 1'b1;
          m_wm = wm;
          m_wl = wl;
        end else begin
          m_ov = 1'b1;
        end
      end else if (m_v && rdy) begin
        m_v = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model with the edge, sample #1 later.
  task automatic applyStimulus(input logic clr, input logic sv, input logic sd,
                               input logic fs, input logic rdy);
    clear       = clr;
    ser_valid   = sv;
    ser_data    = sd;
    frame_start = fs;
    out_ready   = rdy;
    @(posedge clock);
    modelStep(clr, sv, sd, fs, rdy);
    #1;
  endtask

  task automatic checkField(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic checkOutput(input string tag, input logic v, input logic [3:0] dm,
                             input logic [3:0] dl, input int cnt, input logic fe,
                             input logic ov);
    checkField({tag, " valid_m"}, valid_m, v);
    checkField({tag, " valid_l"}, valid_l, v);
    checkField({tag, " data_m"},  data_m,  dm);
    checkField({tag, " data_l"},  data_l,  dl);
    checkField({tag, " cnt_m"},   cnt_m,   cnt);
    checkField({tag, " cnt_l"},   cnt_l,   cnt);
    checkField({tag, " ferr_m"},  ferr_m,  fe);
    checkField({tag, " ferr_l"},  ferr_l,  fe);
    checkField({tag, " ovr_m"},   ovr_m,   ov);
    checkField({tag, " ovr_l"},   ovr_l,   ov);
  endtask

  typedef struct {
    logic       clr, sv, sd, fs, rdy;
    logic       v;
    logic [3:0] dm, dl;
    int         cnt;
    logic       fe, ov;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic clr, input logic sv, input logic sd, input logic fs,
                        input logic rdy, input logic v, input logic [3:0] dm,
                        input logic [3:0] dl, input int cnt, input logic fe,
                        input logic ov);
    vec_t t;
    t.clr = clr; t.sv = sv; t.sd = sd; t.fs = fs; t.rdy = rdy;
    t.v = v; t.dm = dm; t.dl = dl; t.cnt = cnt; t.fe = fe; t.ov = ov;
    vecs.push_back(t);
  endtask

  initial begin
    //     clr sv sd fs rdy   v  dm       dl     cnt fe ov
    // basic word 1,0,1,1 with the sink ready
    addVec(0, 1, 1, 1, 1,   0, 4'b0000, 4'b0000, 1, 0, 0);
    addVec(0, 1, 0, 0, 1,   0, 4'b0000, 4'b0000, 2, 0, 0);
    addVec(0, 1, 1, 0, 1,   0, 4'b0000, 4'b0000, 3, 0, 0);
    addVec(0, 1, 1, 0, 1,   1, 4'b1011, 4'b1101, 0, 0, 0);
    addVec(0, 0, 0, 0, 1,   0, 4'b1011, 4'b1101, 0, 0, 0);
    // backpressure: 1011 then 0110 back-to-back, second word dropped
    addVec(0, 1, 1, 1, 0,   0, 4'b1011, 4'b1101, 1, 0, 0);
    addVec(0, 1, 0, 0, 0,   0, 4'b1011, 4'b1101, 2, 0, 0);
    addVec(0, 1, 1, 0, 0,   0, 4'b1011, 4'b1101, 3, 0, 0);
    addVec(0, 1, 1, 0, 0,   1, 4'b1011, 4'b1101, 0, 0, 0);
    addVec(0, 1, 0, 0, 0,   1, 4'b1011, 4'b1101, 1, 0, 0);
    addVec(0, 1, 1, 0, 0,   1, 4'b1011, 4'b1101, 2, 0, 0);
    addVec(0, 1, 1, 0, 0,   1, 4'b1011, 4'b1101, 3, 0, 0);
    addVec(0, 1, 0, 0, 0,   1, 4'b1011, 4'b1101, 0, 0, 1);
    addVec(0, 0, 0, 0, 1,   0, 4'b1011, 4'b1101, 0, 0, 1);
    addVec(0, 0, 0, 0, 0,   0, 4'b1011, 4'b1101, 0, 0, 1);
    addVec(1, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0);
    // mid-word frame_start: partial 11 discarded, then 0010
    addVec(0, 1, 1, 1, 1,   0, 4'b0000, 4'b0000, 1, 0, 0);
    addVec(0, 1, 1, 0, 1,   0, 4'b0000, 4'b0000, 2, 0, 0);
    addVec(0, 1, 0, 1, 1,   0, 4'b0000, 4'b0000, 1, 1, 0);
    addVec(0, 1, 0, 0, 1,   0, 4'b0000, 4'b0000, 2, 0, 0);
    addVec(0, 1, 1, 0, 1,   0, 4'b0000, 4'b0000, 3, 0, 0);
    addVec(0, 1, 0, 0, 1,   1, 4'b0010, 4'b0100, 0, 0, 0);
    // drain and refill on the same edge: 0101 replaces 0010
    addVec(0, 1, 0, 0, 0,   1, 4'b0010, 4'b0100, 1, 0, 0);
    addVec(0, 1, 1, 0, 0,   1, 4'b0010, 4'b0100, 2, 0, 0);
    addVec(0, 1, 0, 0, 0,   1, 4'b0010, 4'b0100, 3, 0, 0);
    addVec(0, 1, 1, 0, 1,   1, 4'b0101, 4'b1010, 0, 0, 0);
    addVec(0, 0, 0, 0, 1,   0, 4'b0101, 4'b1010, 0, 0, 0);
    // gaps inside a word, frame_start without ser_valid ignored
    addVec(0, 1, 1, 1, 1,   0, 4'b0101, 4'b1010, 1, 0, 0);
    addVec(0, 0, 0, 1, 1,   0, 4'b0101, 4'b1010, 1, 0, 0);
    addVec(0, 1, 0, 0, 1,   0, 4'b0101, 4'b1010, 2, 0, 0);
    addVec(0, 0, 1, 0, 1,   0, 4'b0101, 4'b1010, 2, 0, 0);
    addVec(0, 1, 0, 0, 1,   0, 4'b0101, 4'b1010, 3, 0, 0);
    addVec(0, 0, 1, 1, 1,   0, 4'b0101, 4'b1010, 3, 0, 0);
    addVec(0, 1, 1, 0, 1,   1, 4'b1001, 4'b1001, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,   1, 4'b1001, 4'b1001, 0, 0, 0);
    addVec(0, 0, 0, 0, 1,   0, 4'b1001, 4'b1001, 0, 0, 0);
    // idle after clear ignores bits without frame_start
    addVec(1, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0);
    addVec(0, 1, 1, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0);
    addVec(0, 1, 1, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0);

    rst = 1'b1; clear = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
    frame_start = 1'b0; out_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset", 1'b0, 4'h0, 4'h0, 0, 1'b0, 1'b0);
    rst = 1'b0;

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].clr, vecs[i].sv, vecs[i].sd, vecs[i].fs, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].v, vecs[i].dm, vecs[i].dl,
                  vecs[i].cnt, vecs[i].fe, vecs[i].ov);
    end

    $display("[TB] asynchronous reset mid-word");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("pre_rst", 1'b1, 4'b1011, 4'b1101, 2, 1'b0, 1'b0);
    ser_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 1'b0, 4'h0, 4'h0, 0, 1'b0, 1'b0);
    modelReset();
    #1;
    rst = 1'b0;
    applyStimulus(0, 1, 1, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("idle_ignore", 1'b0, 4'h0, 4'h0, 0, 1'b0, 1'b0);

    $display("[TB] randomized stream against model");
    for (int n = 0; n < 600; n++) begin
      logic clr, sv, sd, fs, rdy;
      clr = ($urandom_range(63) == 0);
      sv  = ($urandom_range(9) < 7);
      sd  = $urandom_range(1);
      fs  = ($urandom_range(7) == 0);
      rdy = $urandom_range(1);
      applyStimulus(clr, sv, sd, fs, rdy);
      checkOutput($sformatf("rand%0d", n), m_v, m_wm, m_wl, m_bits.size(), m_fe, m_ov);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
Serial-in/parallel-out receiver. It is the inverse of the team's universal shift register: it collects a framed serial bit stream into WIDTH-bit words. Completed words are presented on a one-entry output buffer with a valid/ready handshake. It sits at the receive end of serial links fed by the shift-register serializers and hands words to downstream parallel logic.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].

Ports:
clock  input  1  single clock; all logic on the posedge.
rst  input  1  asynchronous, active-high reset.
clear  input  1  synchronous flush of FSM, counter, buffer and flags.
ser_valid  input  1  ser_data is valid this cycle.
ser_data  input  1  serial data bit.
frame_start  input  1  qualified by ser_valid; marks the current bit as bit 0 of a word.
out_valid  output  1  data_out holds an undelivered word.
out_ready  input  1  downstream accepts the word when out_valid=1.
data_out  output  WIDTH  assembled word.
bit_cnt  output  $clog2(WIDTH)  number of bits collected in the current partial word.
frame_err  output  1  one-cycle pulse when a partial word is discarded.
overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (rst=1, asynchronous) and clear=1 (synchronous) produce the same state:
  - FSM = IDLE; bit_cnt=0; shift register = 0.
  - out_valid=0; data_out=0; frame_err=0; overrun=0.
- If clear and rst are both asserted, rst wins; clear has priority over all other inputs.
- Shift operation on an accepted bit:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], ser_data}.
  - MSB_FIRST=0: sreg <= {ser_data, sreg[WIDTH-1:1]}.
- FSM state IDLE:
  - ser_valid with frame_start=0: bit ignored.
  - ser_valid with frame_start=1: shift the bit in, bit_cnt=1, go to SHIFT.
- FSM state SHIFT:
  - Each ser_valid shifts one bit and increments bit_cnt.
  - When the accepted bit is bit WIDTH-1, the word is complete: bit_cnt wraps to 0 and the FSM stays in SHIFT, so a back-to-back stream continues without gaps.
- frame_start in SHIFT:
  - With bit_cnt=0 (word boundary): normal; the bit starts a new word.
  - With bit_cnt!=0: the partial word is discarded, frame_err pulses for 1 cycle (the cycle after), the bit becomes bit 0, and bit_cnt=1.
- frame_start without ser_valid is ignored in every state.
- Word completion and the output buffer:
  - Latency: out_valid and data_out update on the clock edge that accepts the last bit, so they are visible the cycle after that bit is presented.
  - Load condition: the buffer loads when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle. In that second case the drain and the refill happen together, with no bubble and no overrun.
  - Overrun: if out_valid=1, out_ready=0 and a word completes, the new word is dropped. data_out keeps the old word and overrun is set; only reset or clear clears it.
- Handshake:
  - A transfer happens on any cycle with out_valid=1 and out_ready=1.
  - With no reload that cycle, out_valid falls on the next edge.
  - data_out is held stable while out_valid=1 and out_ready=0.
- Data ordering: shifting into the bit register never alters data_out directly; the buffer is separate from the shift register.
- Width: bit_cnt counts 0..WIDTH-1 and never reaches WIDTH.

Decomposition:
- Package shift_pkg:
  - typedef enum logic {S_IDLE, S_SHIFT} deser_state_t.
  - Localparam helper for the counter width, CNT_W = (WIDTH>1) ? $clog2(WIDTH) : 1.
- One natural sub-module: deser_out_buf, the one-entry valid/ready holding register with overrun detection.
- The shift register, counter and FSM stay in the top module.

Test Plan:
1. WIDTH=4, MSB_FIRST=1: bits 1,0,1,1 on consecutive cycles, frame_start on the first, out_ready=1 -> data_out=4'b1011 and out_valid=1 one cycle after the 4th bit, then out_valid=0.
2. MSB_FIRST=0: same bits 1,0,1,1 -> data_out=4'b1101.
3. Backpressure with out_ready=0: stream 1011 then 0110 back-to-back -> data_out stays 4'b1011 and overrun=1. Then raise out_ready -> one transfer of 1011, out_valid=0, overrun remains 1 until clear.
4. Mid-word frame_start: bits 1,1 (frame_start on the first), then frame_start with bits 0,0,1,0 -> frame_err pulses once, data_out=4'b0010, and the partial 11 never appears.
5. Simultaneous drain and refill: out_valid=1 holding 1011, out_ready=1 on the cycle the 4th bit of 0101 arrives -> 1011 transfers, data_out=4'b0101 next cycle, out_valid stays 1, overrun=0.
6. Reset and gaps:
   - Assert rst asynchronously after 2 bits -> all outputs 0 immediately; bits without frame_start are then ignored (bit_cnt=0).
   - ser_valid gaps inside a word do not corrupt it: bits 1,0,0,1 with idle cycles between them -> 4'b1001.
